mem_arbiter_n: RTL

//  N-port arbiter multiplexing requesters (I-fetch, D-mem, later L2/DMA) onto one

---
 rtl/mem_arbiter_n.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter_n.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_n
//  Description : N-port memory arbiter. Grants one requester at a time onto a
//                single memory port using fixed or round-robin priority, holds
//                registered memory-side outputs stable until the memory
//                responds, then returns a one-hot done pulse to the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_n #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter bit RR_MODE    = 1'b1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS-1:0]                req_read,
  input  logic [NUM_PORTS-1:0]                req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]     req_address,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]     req_wdata,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_wmask,
  output logic [NUM_PORTS-1:0]                req_resp,
  output logic [DATA_WIDTH-1:0]               req_rdata,
  output logic                                mem_read,
  output logic                                mem_write,
  output logic [ADDR_WIDTH-1:0]               mem_address,
  output logic [DATA_WIDTH-1:0]               mem_wdata,
  output logic [DATA_WIDTH/8-1:0]             mem_byte_enable,
  input  logic                                mem_resp,
  input  logic [DATA_WIDTH-1:0]               mem_rdata,
  output logic                                busy,
  output logic [$clog2(NUM_PORTS)-1:0]        grant_idx
);

  localparam int                 c_IDX_W    = $clog2(NUM_PORTS);
  localparam int                 c_BE_W     = DATA_WIDTH / 8;
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(NUM_PORTS - 1);
  localparam logic [c_IDX_W:0]   c_PORTS    = (c_IDX_W + 1)'(NUM_PORTS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [c_IDX_W-1:0]     r_rr_ptr;
  logic                   w_start;
  logic                   w_done;

  logic [NUM_PORTS-1:0]   w_active;
  logic                   w_any;
  logic [c_IDX_W-1:0]     w_base;
  logic [2*NUM_PORTS-1:0] w_dbl;
  logic [NUM_PORTS-1:0]   w_rot;
  logic [c_IDX_W-1:0]     w_off;
  logic [c_IDX_W:0]       w_sum;
  logic [c_IDX_W-1:0]     w_winner;

  logic                   w_sel_write;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [DATA_WIDTH-1:0]  w_sel_wdata;
  logic [c_BE_W-1:0]      w_sel_mask;

  // A port is asking for service if it raises either strobe.
  assign w_active = req_read | req_write;
  assign w_any    = |w_active;

  // Fixed priority is round-robin with the search always starting at port 0.
  assign w_base = RR_MODE ? r_rr_ptr : '0;

  // Rotate the request vector so bit j stands for port (base + j) mod N.
  assign w_dbl = {w_active, w_active} >> w_base;
  assign w_rot = w_dbl[NUM_PORTS-1:0];

  // Lowest set bit of the rotated vector is the distance from base to the winner.
  always_comb begin
    w_off = '0;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (w_rot[j]) w_off = c_IDX_W'(j);
    end
    w_sum = {1'b0, w_base} + {1'b0, w_off};
    if (w_sum >= c_PORTS) w_sum = w_sum - c_PORTS;
    w_winner = w_sum[c_IDX_W-1:0];
  end

  // Pick out the winning port's operation and payload; write beats read.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_mask  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_winner == c_IDX_W'(i)) begin
        w_sel_write = req_write[i];
        w_sel_addr  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_mask  = req_wmask[i*c_BE_W +: c_BE_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: start on any request in IDLE, finish on memory response.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next_state = ST_BUSY;
          w_start      = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_resp) begin
          w_next_state = ST_IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Memory-side registers: latch the winner on start, drop strobes on done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
      grant_idx       <= '0;
      r_rr_ptr        <= '0;
    end else if (w_start) begin
      mem_read        <= ~w_sel_write;
      mem_write       <= w_sel_write;
      mem_address     <= w_sel_addr;
      mem_wdata       <= w_sel_wdata;
      mem_byte_enable <= w_sel_mask;
      grant_idx       <= w_winner;
    end else if (w_done) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      r_rr_ptr  <= (grant_idx == c_LAST_IDX) ? '0 : grant_idx + 1'b1;
    end
  end

  // Done pulse goes only to the granted port, and only while busy.
  always_comb begin
    req_resp = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_done && (grant_idx == c_IDX_W'(i))) req_resp[i] = 1'b1;
    end
  end

  assign req_rdata = w_done ? mem_rdata : '0;
  assign busy      = (r_state == ST_BUSY);

  // A requester must not raise read and write together; the write would win.
  always_ff @(posedge clk) begin
    if (!reset) assert (~|(req_read & req_write));
  end

endmodule
`default_nettype wire
